bulk_ep_arbiter: RTL and testbench

BULK_EP_ARBITER -- requirements
Module: bulk_ep_arbiter

---
 rtl/bulk_ep_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bulk_ep_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bulk_ep_arbiter.sv
// bulk_ep_arbiter
//   Arbitrates CHANNELS bulk-IN AXI-Stream sources onto one byte stream for
//   the USB bridge. The bridge asks for a bulk transaction on an endpoint.
//   Channel k serves endpoint EP_BASE+k. The selected source is connected to
//   the output until a last beat, a MAX_PACKET boundary, or loss of the
//   bulk cycle ends the transaction.
//
// Ports
//   clock            rising-edge clock
//   areset_n         asynchronous active-low reset, released synchronously
//   configured_i     device enumerated and configured
//   level_i          per-channel FIFO levels, channel k at [k*LBITS +: LBITS]
//   blk_in_ready_o   per-channel IN data available (registered)
//   blk_out_ready_o  per-channel OUT space available (registered)
//   blk_start_i      bulk transaction start pulse
//   blk_cycle_i      bulk transaction active level
//   blk_endpt_i      target endpoint of the transaction
//   s_tvalid_i, s_tlast_i, s_tdata_i, s_tready_o   per-channel sources
//   m_tvalid_o, m_tlast_o, m_tdata_o, m_tready_i   muxed stream to the bridge
module bulk_ep_arbiter #(
  parameter int         CHANNELS   = 2,
  parameter logic [3:0] EP_BASE    = 4'd1,
  parameter int         LBITS      = 11,
  parameter int         IN_THRESH  = 4,
  parameter int         OUT_LIMIT  = 1024,
  parameter int         MAX_PACKET = 512
) (
  input  logic                    clock,
  input  logic                    areset_n,
  input  logic                    configured_i,
  input  logic [CHANNELS*LBITS-1:0] level_i,
  output logic [CHANNELS-1:0]     blk_in_ready_o,
  output logic [CHANNELS-1:0]     blk_out_ready_o,
  input  logic                    blk_start_i,
  input  logic                    blk_cycle_i,
  input  logic [3:0]              blk_endpt_i,
  input  logic [CHANNELS-1:0]     s_tvalid_i,
  input  logic [CHANNELS-1:0]     s_tlast_i,
  input  logic [CHANNELS*8-1:0]   s_tdata_i,
  output logic [CHANNELS-1:0]     s_tready_o,
  output logic                    m_tvalid_o,
  output logic                    m_tlast_o,
  output logic [7:0]              m_tdata_o,
  input  logic                    m_tready_i
);

  localparam int DATA_W = 8;
  localparam int SW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW     = $clog2(MAX_PACKET + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_PACKET - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                state;
  logic [SW-1:0]         sel;
  logic [CW-1:0]         count;
  logic                  rst_n_p1;
  logic [CHANNELS-1:0]   in_rdy_p1;
  logic [CHANNELS-1:0]   out_rdy_p1;
  logic [CHANNELS-1:0]   xfer_mask;
  logic                  start_ok;
  logic [SW-1:0]         start_chan;
  logic                  beat;

  function automatic logic lvl_above(input logic [LBITS-1:0] lvl);
    return int'(lvl) > IN_THRESH;
  endfunction

  function automatic logic lvl_below(input logic [LBITS-1:0] lvl);
    return int'(lvl) < OUT_LIMIT;
  endfunction

  function automatic logic ep_hit(input logic [3:0] ep);
    int off;
    off = int'(ep) - int'(EP_BASE);
    return (off >= 0) && (off < CHANNELS);
  endfunction

  function automatic logic [SW-1:0] ep_chan(input logic [3:0] ep);
    return SW'(int'(ep) - int'(EP_BASE));
  endfunction

  // ---- reset release stage: assert asynchronously, release on a clean edge
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) rst_n_p1 <= 1'b0;
    else           rst_n_p1 <= 1'b1;
  end

  // ---- stage p1: registered readiness flags
  always_ff @(posedge clock or negedge rst_n_p1) begin
    if (!rst_n_p1) begin
      in_rdy_p1  <= '0;
      out_rdy_p1 <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        in_rdy_p1[k]  <= configured_i && lvl_above(level_i[k*LBITS +: LBITS]);
        out_rdy_p1[k] <= configured_i && lvl_below(level_i[k*LBITS +: LBITS]);
      end
    end
  end

  assign blk_in_ready_o  = in_rdy_p1 & ~xfer_mask;
  assign blk_out_ready_o = out_rdy_p1;

  assign start_chan = ep_chan(blk_endpt_i);

  always_comb begin
    start_ok = 1'b0;
    if (blk_start_i && ep_hit(blk_endpt_i)) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (start_chan == SW'(k)) start_ok = blk_in_ready_o[k];
      end
    end
  end

  // ---- transaction FSM: channel latch and byte counter
  always_ff @(posedge clock or negedge rst_n_p1) begin
    if (!rst_n_p1) begin
      state <= IDLE;
      sel   <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state <= XFER;
            sel   <= start_chan;
            count <= '0;
          end
        end
        XFER: begin
          if (beat) begin
            count <= count + CW'(1);
            if (m_tlast_o) state <= DONE;
          end else if (!blk_cycle_i) begin
            state <= IDLE;
            count <= '0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- combinational stream mux
  always_comb begin
    m_tvalid_o = 1'b0;
    m_tlast_o  = 1'b0;
    m_tdata_o  = '0;
    s_tready_o = '0;
    xfer_mask  = '0;
    if (state == XFER) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (sel == SW'(k)) begin
          xfer_mask[k]  = 1'b1;
          m_tvalid_o    = s_tvalid_i[k] && blk_cycle_i;
          m_tdata_o     = s_tdata_i[k*DATA_W +: DATA_W];
          s_tready_o[k] = m_tready_i && blk_cycle_i;
          m_tlast_o     = s_tlast_i[k] || (count == LAST_CNT);
        end
      end
    end
  end

  assign beat = m_tvalid_o && m_tready_i;

endmodule

// File: tb/tb_bulk_ep_arbiter.sv
// tb_bulk_ep_arbiter
//   Self-checking bench for bulk_ep_arbiter with default parameters
//   (2 channels, endpoints 1 and 2, MAX_PACKET 512). Expected output beats
//   are queued when a source stream is set up and popped on each handshake.
module tb_bulk_ep_arbiter;
  localparam int CH = 2;
  localparam int LB = 11;

  logic              clock = 1'b0;
  logic              areset_n;
  logic              configured_i;
  logic [CH*LB-1:0]  level_i;
  logic [CH-1:0]     blk_in_ready_o, blk_out_ready_o;
  logic              blk_start_i, blk_cycle_i;
  logic [3:0]        blk_endpt_i;
  logic [CH-1:0]     s_tvalid_i, s_tlast_i, s_tready_o;
  logic [CH*8-1:0]   s_tdata_i;
  logic              m_tvalid_o, m_tlast_o, m_tready_i;
  logic [7:0]        m_tdata_o;

  int         n_vec, n_bad, src_idx;
  bit         stall_en;
  logic [8:0] exp_q[$];

  always #5 clock = ~clock;

  bulk_ep_arbiter dut (
    .clock(clock), .areset_n(areset_n), .configured_i(configured_i),
    .level_i(level_i), .blk_in_ready_o(blk_in_ready_o),
    .blk_out_ready_o(blk_out_ready_o), .blk_start_i(blk_start_i),
    .blk_cycle_i(blk_cycle_i), .blk_endpt_i(blk_endpt_i),
    .s_tvalid_i(s_tvalid_i), .s_tlast_i(s_tlast_i), .s_tdata_i(s_tdata_i),
    .s_tready_o(s_tready_o), .m_tvalid_o(m_tvalid_o), .m_tlast_o(m_tlast_o),
    .m_tdata_o(m_tdata_o), .m_tready_i(m_tready_i)
  );

  function automatic logic [7:0] pat(input int ch, input int j);
    return 8'((j * 7 + 3 + ch * 16) & 255);
  endfunction

  task automatic set_level(input int ch, input int v);
    level_i[ch*LB +: LB] = LB'(v);
  endtask

  task automatic push_pkt(input int ch, input int first, input int n, input bit last_on_end);
    logic lb;
    for (int j = 0; j < n; j++) begin
      lb = last_on_end && (j == n - 1);
      exp_q.push_back({lb, pat(ch, first + j)});
    end
  endtask

  task automatic do_start(input logic [3:0] ep);
    blk_endpt_i = ep;
    blk_start_i = 1'b1;
    @(posedge clock); #1;
    blk_start_i = 1'b0;
  endtask

  // Drives channel ch from src_idx; monitors handshakes against exp_q.
  task automatic pump(input int ch, input int nsrc, input int last_at, input int max_beats,
                      input int budget, output int beats, output bit saw_last);
    logic [8:0] got, want;
    bit hs, cons;
    beats = 0;
    saw_last = 0;
    for (int c = 0; c < budget; c++) begin
      s_tvalid_i = '0;
      s_tlast_i  = '0;
      s_tvalid_i[ch] = (src_idx < nsrc);
      s_tdata_i[ch*8 +: 8] = pat(ch, src_idx);
      s_tlast_i[ch] = (last_at != 0) && (src_idx == last_at - 1);
      m_tready_i = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clock);
      hs   = m_tvalid_o && m_tready_i;
      cons = s_tready_o[ch] && s_tvalid_i[ch];
      if (hs || cons) begin
        n_vec++;
        if (hs !== cons) begin n_bad++; $display("FAIL hs_vs_src got hs=%0b src=%0b want equal", hs, cons); end
      end
      if (hs) begin
        got = {m_tlast_o, m_tdata_o};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL beat_extra got %h want none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin n_bad++; $display("FAIL beat got last=%0b data=%h want last=%0b data=%h", got[8], got[7:0], want[8], want[7:0]); end
        end
        beats++;
        if (m_tlast_o) saw_last = 1;
      end
      if (cons) src_idx++;
      @(posedge clock); #1;
      if (saw_last || (max_beats != 0 && beats == max_beats)) break;
    end
    m_tready_i = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    s_tvalid_i = '1; s_tdata_i = 16'hA5A5; s_tlast_i = '1;
    #1;
    n_vec++; if (blk_in_ready_o !== 2'b00) begin n_bad++; $display("FAIL rst_in_ready got %b want 00", blk_in_ready_o); end
    n_vec++; if (blk_out_ready_o !== 2'b00) begin n_bad++; $display("FAIL rst_out_ready got %b want 00", blk_out_ready_o); end
    n_vec++; if (s_tready_o !== 2'b00) begin n_bad++; $display("FAIL rst_s_tready got %b want 00", s_tready_o); end
    n_vec++; if (m_tvalid_o !== 1'b0) begin n_bad++; $display("FAIL rst_m_tvalid got %b want 0", m_tvalid_o); end
    n_vec++; if (m_tlast_o !== 1'b0) begin n_bad++; $display("FAIL rst_m_tlast got %b want 0", m_tlast_o); end
    n_vec++; if (m_tdata_o !== 8'h00) begin n_bad++; $display("FAIL rst_m_tdata got %h want 00", m_tdata_o); end
    s_tvalid_i = '0; s_tlast_i = '0; s_tdata_i = '0;
    @(posedge clock); #3;
    areset_n = 1'b1;
    @(posedge clock); #1;
    n_vec++; if (blk_in_ready_o !== 2'b00) begin n_bad++; $display("FAIL rel_sync_edge got %b want 00", blk_in_ready_o); end
    @(posedge clock); #1;
    n_vec++; if (blk_in_ready_o !== 2'b11) begin n_bad++; $display("FAIL rel_in_ready got %b want 11", blk_in_ready_o); end
    n_vec++; if (blk_out_ready_o !== 2'b11) begin n_bad++; $display("FAIL rel_out_ready got %b want 11", blk_out_ready_o); end
  endtask

  task automatic test_ready();
    set_level(0, 5); set_level(1, 4);
    @(posedge clock); #1;
    n_vec++; if (blk_in_ready_o !== 2'b01) begin n_bad++; $display("FAIL thresh_in got %b want 01", blk_in_ready_o); end
    n_vec++; if (blk_out_ready_o !== 2'b11) begin n_bad++; $display("FAIL thresh_out got %b want 11", blk_out_ready_o); end
    set_level(0, 1024); set_level(1, 1023);
    #1;
    n_vec++; if (blk_out_ready_o !== 2'b11) begin n_bad++; $display("FAIL out_latency got %b want 11", blk_out_ready_o); end
    @(posedge clock); #1;
    n_vec++; if (blk_out_ready_o !== 2'b10) begin n_bad++; $display("FAIL limit_out got %b want 10", blk_out_ready_o); end
    n_vec++; if (blk_in_ready_o !== 2'b11) begin n_bad++; $display("FAIL limit_in got %b want 11", blk_in_ready_o); end
    configured_i = 1'b0;
    @(posedge clock); #1;
    n_vec++; if (blk_in_ready_o !== 2'b00) begin n_bad++; $display("FAIL unconf_in got %b want 00", blk_in_ready_o); end
    n_vec++; if (blk_out_ready_o !== 2'b00) begin n_bad++; $display("FAIL unconf_out got %b want 00", blk_out_ready_o); end
    configured_i = 1'b1; set_level(0, 5); set_level(1, 5);
    @(posedge clock); #1;
    n_vec++; if (blk_in_ready_o !== 2'b11) begin n_bad++; $display("FAIL restore_in got %b want 11", blk_in_ready_o); end
  endtask

  task automatic test_packet();
    int beats; bit sl;
    src_idx = 0; stall_en = 1;
    push_pkt(1, 0, 10, 1);
    do_start(4'd2);
    n_vec++; if (s_tready_o !== 2'b10) begin n_bad++; $display("FAIL pkt_sel got %b want 10", s_tready_o); end
    n_vec++; if (blk_in_ready_o !== 2'b01) begin n_bad++; $display("FAIL pkt_in_mask got %b want 01", blk_in_ready_o); end
    pump(1, 10, 10, 0, 200, beats, sl);
    stall_en = 0; s_tvalid_i = '0; s_tlast_i = '0;
    n_vec++; if (beats !== 10) begin n_bad++; $display("FAIL pkt_beats got %0d want 10", beats); end
    n_vec++; if (sl !== 1'b1) begin n_bad++; $display("FAIL pkt_last got %0b want 1", sl); end
    n_vec++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL pkt_left got %0d want 0", exp_q.size()); end
    n_vec++; if (s_tready_o !== 2'b00) begin n_bad++; $display("FAIL done_s_tready got %b want 00", s_tready_o); end
    do_start(4'd2);
    n_vec++; if (s_tready_o !== 2'b00) begin n_bad++; $display("FAIL done_ignore got %b want 00", s_tready_o); end
    do_start(4'd2);
    n_vec++; if (s_tready_o !== 2'b10) begin n_bad++; $display("FAIL idle_restart got %b want 10", s_tready_o); end
    blk_cycle_i = 1'b0;
    @(posedge clock); #1;
    blk_cycle_i = 1'b1; #1;
    n_vec++; if (s_tready_o !== 2'b00) begin n_bad++; $display("FAIL cycle_drop got %b want 00", s_tready_o); end
  endtask

  task automatic test_bad_ep();
    s_tvalid_i = '1;
    do_start(4'd7);
    n_vec++; if (s_tready_o !== 2'b00) begin n_bad++; $display("FAIL ep7_s_tready got %b want 00", s_tready_o); end
    n_vec++; if (m_tvalid_o !== 1'b0) begin n_bad++; $display("FAIL ep7_m_tvalid got %b want 0", m_tvalid_o); end
    n_vec++; if (blk_in_ready_o !== 2'b11) begin n_bad++; $display("FAIL ep7_in_ready got %b want 11", blk_in_ready_o); end
    do_start(4'd0);
    n_vec++; if (s_tready_o !== 2'b00) begin n_bad++; $display("FAIL ep0_s_tready got %b want 00", s_tready_o); end
    set_level(0, 3);
    @(posedge clock); #1;
    do_start(4'd1);
    n_vec++; if (s_tready_o !== 2'b00) begin n_bad++; $display("FAIL notready_start got %b want 00", s_tready_o); end
    set_level(0, 5); s_tvalid_i = '0;
    @(posedge clock); #1;
  endtask

  task automatic test_cfg_drop();
    do_start(4'd1);
    n_vec++; if (s_tready_o !== 2'b01) begin n_bad++; $display("FAIL cfg_start got %b want 01", s_tready_o); end
    configured_i = 1'b0;
    @(posedge clock); #1;
    n_vec++; if (blk_out_ready_o !== 2'b00) begin n_bad++; $display("FAIL cfg_out got %b want 00", blk_out_ready_o); end
    n_vec++; if (blk_in_ready_o !== 2'b00) begin n_bad++; $display("FAIL cfg_in got %b want 00", blk_in_ready_o); end
    n_vec++; if (s_tready_o !== 2'b01) begin n_bad++; $display("FAIL cfg_no_abort got %b want 01", s_tready_o); end
    configured_i = 1'b1; blk_cycle_i = 1'b0;
    @(posedge clock); #1;
    blk_cycle_i = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_max_packet();
    int beats; bit sl;
    src_idx = 0;
    push_pkt(0, 0, 512, 1);
    do_start(4'd1);
    pump(0, 600, 0, 0, 2000, beats, sl);
    s_tvalid_i[0] = 1'b1; s_tdata_i[7:0] = pat(0, src_idx);
    #1;
    n_vec++; if (beats !== 512) begin n_bad++; $display("FAIL max_beats got %0d want 512", beats); end
    n_vec++; if (sl !== 1'b1) begin n_bad++; $display("FAIL max_last got %0b want 1", sl); end
    n_vec++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL max_left got %0d want 0", exp_q.size()); end
    n_vec++; if (src_idx !== 512) begin n_bad++; $display("FAIL max_src_idx got %0d want 512", src_idx); end
    n_vec++; if (s_tready_o !== 2'b00) begin n_bad++; $display("FAIL max_b513_held got %b want 00", s_tready_o); end
    @(posedge clock); #1;
    s_tvalid_i = '0;
  endtask

  task automatic test_abort();
    int beats; bit sl;
    src_idx = 0;
    push_pkt(1, 0, 3, 0);
    do_start(4'd2);
    pump(1, 600, 0, 3, 100, beats, sl);
    n_vec++; if (beats !== 3) begin n_bad++; $display("FAIL abort_beats got %0d want 3", beats); end
    n_vec++; if (sl !== 1'b0) begin n_bad++; $display("FAIL abort_last got %0b want 0", sl); end
    blk_cycle_i = 1'b0; s_tvalid_i = '0;
    @(posedge clock); #1;
    blk_cycle_i = 1'b1; #1;
    n_vec++; if (s_tready_o !== 2'b00) begin n_bad++; $display("FAIL abort_idle got %b want 00", s_tready_o); end
    n_vec++; if (src_idx !== 3) begin n_bad++; $display("FAIL abort_src_idx got %0d want 3", src_idx); end
    push_pkt(1, 3, 512, 1);
    do_start(4'd2);
    pump(1, 600, 0, 0, 2000, beats, sl);
    n_vec++; if (beats !== 512) begin n_bad++; $display("FAIL resume_beats got %0d want 512", beats); end
    n_vec++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL resume_left got %0d want 0", exp_q.size()); end
    n_vec++; if (src_idx !== 515) begin n_bad++; $display("FAIL resume_src_idx got %0d want 515", src_idx); end
    s_tvalid_i = '0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    int beats; bit sl;
    src_idx = 0;
    push_pkt(0, 0, 4, 0);
    do_start(4'd1);
    pump(0, 100, 0, 4, 100, beats, sl);
    n_vec++; if (beats !== 4) begin n_bad++; $display("FAIL mid_beats got %0d want 4", beats); end
    #3;
    areset_n = 1'b0;
    #1;
    n_vec++; if (blk_in_ready_o !== 2'b00) begin n_bad++; $display("FAIL mid_in_ready got %b want 00", blk_in_ready_o); end
    n_vec++; if (blk_out_ready_o !== 2'b00) begin n_bad++; $display("FAIL mid_out_ready got %b want 00", blk_out_ready_o); end
    n_vec++; if (s_tready_o !== 2'b00) begin n_bad++; $display("FAIL mid_s_tready got %b want 00", s_tready_o); end
    n_vec++; if (m_tvalid_o !== 1'b0) begin n_bad++; $display("FAIL mid_m_tvalid got %b want 0", m_tvalid_o); end
    n_vec++; if (m_tdata_o !== 8'h00) begin n_bad++; $display("FAIL mid_m_tdata got %h want 00", m_tdata_o); end
    @(posedge clock); #3;
    areset_n = 1'b1;
    @(posedge clock); #1;
    n_vec++; if (blk_in_ready_o !== 2'b00) begin n_bad++; $display("FAIL mid_sync_edge got %b want 00", blk_in_ready_o); end
    @(posedge clock); #1;
    n_vec++; if (blk_in_ready_o !== 2'b11) begin n_bad++; $display("FAIL mid_in_back got %b want 11", blk_in_ready_o); end
    n_vec++; if (s_tready_o !== 2'b00) begin n_bad++; $display("FAIL mid_stays_idle got %b want 00", s_tready_o); end
    do_start(4'd1);
    n_vec++; if (s_tready_o !== 2'b01) begin n_bad++; $display("FAIL mid_fresh_start got %b want 01", s_tready_o); end
    blk_cycle_i = 1'b0; s_tvalid_i = '0;
    @(posedge clock); #1;
    blk_cycle_i = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_bad = 0; src_idx = 0; stall_en = 0;
    areset_n = 1'b0; configured_i = 1'b1; level_i = '0;
    set_level(0, 5); set_level(1, 5);
    blk_start_i = 1'b0; blk_cycle_i = 1'b1; blk_endpt_i = 4'd0;
    s_tvalid_i = '0; s_tlast_i = '0; s_tdata_i = '0; m_tready_i = 1'b1;
    test_reset();
    test_ready();
    test_packet();
    test_bad_ep();
    test_cfg_drop();
    test_max_packet();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
